// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 10407,
  parameter int CNT_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] DIV      = CNT_W'(BAUD_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
`ifdef PARITY_EN
  logic                 parity_bit;
`endif

  assign busy = ~tx_ready;

  // The counter is always reloaded (never cleared) at a bit boundary, so every
  // bit lasts exactly BAUD_DIV+1 cycles; tx is updated on the edge that enters a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= DIV;
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (tx_valid && tx_ready) begin
        shift_reg <= tx_data;
        baud_cnt  <= DIV;
        state     <= START;
        tx        <= 1'b0;
        tx_ready  <= 1'b0;
`ifdef PARITY_EN
        parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - CNT_W'(1);
    end else begin
      baud_cnt <= DIV;
      case (state)
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shift_reg[0];
        end
        DATA: begin
          if (bit_idx == LAST_IDX) begin
`ifdef PARITY_EN
            state <= PARITY;
            tx    <= parity_bit;
`else
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
`endif
          end else begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + IDX_W'(1);
            tx        <= shift_reg[1];
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state    <= STOP;
          stop_cnt <= 1'b0;
          tx       <= 1'b1;
        end
`endif
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx       <= 1'b1;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: two instances (8-1 and 7-2 framing) against a frame-level model.
// Honours PARITY_EN the same way the design does.
module tb_uart_tx_param;

  localparam int DIV = 3;
  localparam int N   = DIV + 1;
  localparam int DB_A = 8, SB_A = 1, ODD_A = 0;
  localparam int DB_B = 7, SB_B = 2, ODD_B = 1;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FA = (1 + DB_A + P + SB_A) * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic       tx_a, ready_a, busy_a, tx_b, ready_b, busy_b;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(DB_A), .STOP_BITS(SB_A), .BAUD_DIV(DIV), .CNT_W(16), .PARITY_ODD(ODD_A)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .busy(busy_a));

  uart_tx_param #(.DATA_BITS(DB_B), .STOP_BITS(SB_B), .BAUD_DIV(DIV), .CNT_W(16), .PARITY_ODD(ODD_B)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .busy(busy_b));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change at a falling edge; the call returns one full cycle later, at the next falling edge.
  task automatic applyStimulus(input bit r, input bit va, input logic [7:0] da, input bit vb, input logic [6:0] dbv);
    rst = r; valid_a = va; data_a = da; valid_b = vb; data_b = dbv;
    @(negedge clk);
  endtask

  // Frame model: a whole frame is laid out as a bit vector; tx is the bit at (cycles elapsed / N).
  bit          m_rdy [2] = '{1'b1, 1'b1};
  bit          m_tx  [2] = '{1'b1, 1'b1};
  bit          m_act [2] = '{1'b0, 1'b0};
  int          m_el  [2] = '{0, 0};
  int          m_len [2] = '{0, 0};
  logic [15:0] m_frame [2];

  function automatic void buildFrame(input logic [8:0] d, input int db, input int sb, input int odd,
                                     output logic [15:0] f, output int len);
    int  p;
    bit  par;
    f   = '0;
    p   = 1;
    par = odd[0];
    for (int k = 0; k < db; k++) begin
      f[p] = d[k];
      par  = par ^ d[k];
      p++;
    end
`ifdef PARITY_EN
    f[p] = par;
    p++;
`endif
    for (int s = 0; s < sb; s++) begin
      f[p] = 1'b1;
      p++;
    end
    len = p;
  endfunction

  function automatic void modelStep(input int i, input bit v, input logic [8:0] d, input int db, input int sb, input int odd);
    logic [15:0] f;
    int          len;
    if (rst) begin
      m_act[i] = 1'b0; m_tx[i] = 1'b1; m_rdy[i] = 1'b1;
    end else if (m_rdy[i] && v) begin
      buildFrame(d, db, sb, odd, f, len);
      m_frame[i] = f; m_len[i] = len; m_el[i] = 0;
      m_act[i] = 1'b1; m_rdy[i] = 1'b0; m_tx[i] = f[0];
    end else if (m_act[i]) begin
      m_el[i]++;
      if (m_el[i] == m_len[i] * N) begin
        m_act[i] = 1'b0; m_tx[i] = 1'b1; m_rdy[i] = 1'b1;
      end else begin
        m_tx[i] = m_frame[i][m_el[i] / N];
      end
    end
  endfunction

  always @(posedge clk) begin
    modelStep(0, valid_a, {1'b0, data_a}, DB_A, SB_A, ODD_A);
    modelStep(1, valid_b, {2'b0, data_b}, DB_B, SB_B, ODD_B);
  end

  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("model tx_a", {31'd0, tx_a}, {31'd0, m_tx[0]});
      checkOutput("model ready_a", {31'd0, ready_a}, {31'd0, m_rdy[0]});
      checkOutput("model busy_a", {31'd0, busy_a}, {31'd0, !m_rdy[0]});
      checkOutput("model tx_b", {31'd0, tx_b}, {31'd0, m_tx[1]});
      checkOutput("model ready_b", {31'd0, ready_b}, {31'd0, m_rdy[1]});
      checkOutput("model busy_b", {31'd0, busy_b}, {31'd0, !m_rdy[1]});
    end
  end

  // Time-ordered bit string such as "0101001011" -> vector with the first character at bit 0.
  function automatic logic [15:0] seqBits(input string s);
    logic [15:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[i] = (s[i] == "1");
    return v;
  endfunction

  // Sends one word and checks every bit period against a literal line pattern.
  task automatic runFrame(input int which, input logic [8:0] d, input string pattern, input string name);
    logic [15:0] exp_bits;
    logic [3:0]  s;
    int          nbits;
    exp_bits = seqBits(pattern);
    nbits    = pattern.len();
    s        = '0;
    if (which == 0) begin valid_a = 1'b1; data_a = d[7:0]; end
    else            begin valid_b = 1'b1; data_b = d[6:0]; end
    @(negedge clk);
    if (which == 0) begin valid_a = 1'b0; data_a = 8'($urandom); end
    else            begin valid_b = 1'b0; data_b = 7'($urandom); end
    for (int c = 0; c < nbits * N; c++) begin
      if (c > 0) @(negedge clk);
      s = {s[2:0], (which == 0) ? tx_a : tx_b};
      if (c % N == N - 1)
        checkOutput($sformatf("%s bit %0d", name, c / N), {28'd0, s}, {28'd0, {4{exp_bits[c / N]}}});
    end
    checkOutput({name, " ready low in last cycle"}, {31'd0, (which == 0) ? ready_a : ready_b}, 32'd0);
    @(negedge clk);
    checkOutput({name, " ready back"}, {31'd0, (which == 0) ? ready_a : ready_b}, 32'd1);
  endtask

  logic tr [0:135];
  logic rd [0:135];

  initial begin
    int lows;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    compare_on = 1'b1;
    checkOutput("reset tx_a", {31'd0, tx_a}, 32'd1);
    checkOutput("reset ready_a", {31'd0, ready_a}, 32'd1);
    checkOutput("reset busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("reset tx_b", {31'd0, tx_b}, 32'd1);

    lows = 0;
    repeat (50) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
      if (tx_a !== 1'b1 || tx_b !== 1'b1) lows++;
    end
    checkOutput("idle line high", lows, 0);

`ifdef PARITY_EN
    runFrame(0, 9'h0A5, "01010010101", "frame A5");
    runFrame(0, 9'h007, "01110000011", "parity even 07");
    runFrame(1, 9'h007, "01110000011", "parity odd 07");
    runFrame(1, 9'h041, "01000001111", "7-bit 41");
`else
    runFrame(0, 9'h0A5, "0101001011", "frame A5");
    runFrame(0, 9'h007, "0111000001", "frame 07");
    runFrame(1, 9'h041, "0100000111", "7-bit 41");
`endif

    // Back-to-back with tx_valid held high, plus a pulse while busy that must be ignored.
    valid_a = 1'b1; data_a = 8'h00;
    @(negedge clk);
    for (int c = 1; c <= 2 * FA + 42; c++) begin
      if (c > 1) @(negedge clk);
      tr[c] = tx_a; rd[c] = ready_a;
      if (c == 1) data_a = 8'hFF;
      if (c == FA + 2) valid_a = 1'b0;
      if (c == FA + 10) begin valid_a = 1'b1; data_a = 8'h3C; end
      if (c == FA + 11) valid_a = 1'b0;
    end
    checkOutput("b2b last data low", {31'd0, tr[FA - N]}, 32'd0);
    lows = 0;
    for (int c = FA - N + 1; c <= FA + 1; c++) if (tr[c] === 1'b1) lows++;
    checkOutput("b2b stop plus gap high cycles", lows, N + 1);
    checkOutput("b2b ready in gap", {31'd0, rd[FA + 1]}, 32'd1);
    checkOutput("b2b second start", {31'd0, tr[FA + 2]}, 32'd0);
    checkOutput("b2b second data", {31'd0, tr[FA + 2 + N]}, 32'd1);
    checkOutput("b2b ready after second", {31'd0, rd[2 * FA + 2]}, 32'd1);
    lows = 0;
    for (int c = 2 * FA + 2; c <= 2 * FA + 42; c++) if (tr[c] !== 1'b1) lows++;
    checkOutput("busy pulse ignored", lows, 0);

    // Reset during data bit 3 truncates the frame.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 7'h00);
    repeat (16) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    checkOutput("midframe reset tx", {31'd0, tx_a}, 32'd1);
    checkOutput("midframe reset ready", {31'd0, ready_a}, 32'd1);
    lows = 0;
    repeat (40) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
      if (tx_a !== 1'b1) lows++;
    end
    checkOutput("no low after reset", lows, 0);

    // Reset wins over a simultaneous accept.
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1, 7'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    checkOutput("reset priority ready_a", {31'd0, ready_a}, 32'd1);
    checkOutput("reset priority tx_b", {31'd0, tx_b}, 32'd1);

    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
                    $urandom_range(0, 3) == 0, 7'($urandom));
    repeat (100) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    checkOutput("final idle ready_a", {31'd0, ready_a}, 32'd1);
    checkOutput("final idle ready_b", {31'd0, ready_b}, 32'd1);

    compare_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
